// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared opcodes, datapath width and FSM state type for the ALU arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_W = 8;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_rr_arbiter_alu.sv
// ============================================================================
// Module : alu
// Brief  : Purely combinational 8-bit ALU (wrap-around arithmetic, logic, shifts, SLT).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [2:0]       op,
    output logic [ALU_W-1:0] result,
    output logic             zero
);

    localparam logic [ALU_W-1:0] c_SH_LIMIT = ALU_W[ALU_W-1:0];

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            // The whole of b is the shift amount, so anything past the width clears the word
            OP_SHL:  result = (b >= c_SH_LIMIT) ? '0 : (a << b[2:0]);
            OP_SHR:  result = (b >= c_SH_LIMIT) ? '0 : (a >> b[2:0]);
            OP_SLT:  result = {{(ALU_W-1){1'b0}}, (a < b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

`default_nettype wire

// File: rtl/alu_rr_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin selector, searching upward from last_grant+1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic [ID_W-1:0]  grant,
    output logic             any
);

    int              w_sum;
    logic [ID_W-1:0] w_idx;

    // Walk from the farthest candidate down so the nearest one after last_grant wins
    always_comb begin
        grant = '0;
        any   = 1'b0;
        w_sum = 0;
        w_idx = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            w_sum = (int'(last_grant) + i) % N_REQ;
            w_idx = w_sum[ID_W-1:0];
            if (req[w_idx]) begin
                grant = w_idx;
                any   = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
// ============================================================================
// Module : alu_rr_arbiter
// Brief  : Round-robin sharing of one ALU among N_REQ requesters, registered
//          id-tagged response. Define ALU_ARB_STATS_EN for stat_ops/stat_stall.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [ALU_W*N_REQ-1:0] req_a,
    input  logic [ALU_W*N_REQ-1:0] req_b,
    input  logic [3*N_REQ-1:0]     req_op,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [ALU_W-1:0]       resp_result,
`ifdef ALU_ARB_STATS_EN
    output logic [15:0]            stat_ops,
    output logic [15:0]            stat_stall,
`endif
    output logic                   resp_zero
);

    state_t           r_state;
    state_t           w_next;
    logic [ID_W-1:0]  r_last;
    logic [ID_W-1:0]  r_id;
    logic [ALU_W-1:0] r_a;
    logic [ALU_W-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_resp_valid;
    logic [ID_W-1:0]  r_resp_id;
    logic [ALU_W-1:0] r_resp_result;
    logic             r_resp_zero;

    logic [ID_W-1:0]  w_grant;
    logic             w_any;
    logic [N_REQ-1:0] w_ready;
    logic [ALU_W-1:0] w_sel_a;
    logic [ALU_W-1:0] w_sel_b;
    logic [2:0]       w_sel_op;
    logic [ALU_W-1:0] w_alu_result;
    logic             w_alu_zero;
    logic             w_accept;
    logic             w_resp_fire;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (r_last),
        .grant      (w_grant),
        .any        (w_any)
    );

    alu u_alu (
        .a      (r_a),
        .b      (r_b),
        .op     (r_op),
        .result (w_alu_result),
        .zero   (w_alu_zero)
    );

    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_sel_a  = req_a[i*ALU_W +: ALU_W];
                w_sel_b  = req_b[i*ALU_W +: ALU_W];
                w_sel_op = req_op[i*3 +: 3];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_ready[w_grant] = 1'b1;
                    w_next           = EXEC;
                end
            end
            EXEC:    w_next = RESP;
            RESP:    if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_accept    = (r_state == IDLE) && w_any;
    assign w_resp_fire = (r_state == RESP) && r_resp_valid && resp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last        <= ID_W'(N_REQ - 1);
            r_id          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_id     <= '0;
            r_resp_result <= '0;
            r_resp_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a    <= w_sel_a;
                r_b    <= w_sel_b;
                r_op   <= w_sel_op;
                r_id   <= w_grant;
                r_last <= w_grant;
            end
            if (r_state == EXEC) begin
                r_resp_valid  <= 1'b1;
                r_resp_result <= w_alu_result;
                r_resp_zero   <= w_alu_zero;
                r_resp_id     <= r_id;
            end else if (w_resp_fire) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    assign req_ready   = w_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_zero   = r_resp_zero;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_stat_ops;
    logic [15:0] r_stat_stall;

    // Both counters stick at all-ones rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_ops   <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_resp_fire && (r_stat_ops != 16'hFFFF)) begin
                r_stat_ops <= r_stat_ops + 16'd1;
            end
            if ((r_state == RESP) && !resp_ready && (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
        end
    end

    assign stat_ops   = r_stat_ops;
    assign stat_stall = r_stat_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
// ============================================================================
// Module : tb_alu_rr_arbiter
// Brief  : Directed scoreboard bench for alu_rr_arbiter (N_REQ = 4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [11:0] req_op;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [7:0]  resp_result;
    logic        resp_zero;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_stall;
`endif

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] res;
        logic       zero;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    alu_rr_arbiter #(.N_REQ(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
`ifdef ALU_ARB_STATS_EN
        .stat_ops    (stat_ops),
        .stat_stall  (stat_stall),
`endif
        .resp_zero   (resp_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; return s[7:0]; end
            3'd1: begin s = {1'b0, a} - {1'b0, b}; return s[7:0]; end
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (b > 8'd7) ? 8'd0 : 8'(a << b);
            3'd6: return (b > 8'd7) ? 8'd0 : 8'(a >> b);
            default: return (a < b) ? 8'd1 : 8'd0;
        endcase
    endfunction

    task automatic set_req(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_a[id*8 +: 8]  = a;
        req_b[id*8 +: 8]  = b;
        req_op[id*3 +: 3] = op;
        req_valid[id]     = 1'b1;
    endtask

    // Starts just after a rising edge in IDLE; covers accept, EXEC and the RESP cycle
    task automatic grant_cycle(input int id, input bit drop, input logic [7:0] exp_res);
        logic [3:0] oh;
        exp_t       e;
        oh     = '0;
        oh[id] = 1'b1;
        @(negedge clk);
        chk("grant", 32'(req_ready), 32'(oh));
        e.id   = 2'(id);
        e.res  = exp_res;
        e.zero = (exp_res == 8'd0);
        q.push_back(e);
        @(posedge clk); #1;
        if (drop) req_valid[id] = 1'b0;
        @(negedge clk);
        chk("exec_req_ready", 32'(req_ready), 32'd0);
        chk("exec_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("latency_resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && resp_valid && resp_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                chk("resp_id", 32'(resp_id), 32'(e.id));
                chk("resp_result", 32'(resp_result), 32'(e.res));
                chk("resp_zero", 32'(resp_zero), 32'(e.zero));
            end
        end
    end

    initial begin
        logic [7:0] ra, rb;
        logic [2:0] rop;
        int         rid;
        logic [7:0] hold_res;

        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_result", 32'(resp_result), 32'd0);
        chk("rst_resp_zero", 32'(resp_zero), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single request with carry discarded
        set_req(1, 3'd0, 8'd200, 8'd100);
        grant_cycle(1, 1'b1, 8'd44);

        // Boundary ops
        set_req(0, 3'd5, 8'h81, 8'd9);   grant_cycle(0, 1'b1, 8'd0);
        set_req(2, 3'd1, 8'd5, 8'd7);    grant_cycle(2, 1'b1, 8'd254);
        set_req(3, 3'd7, 8'd3, 8'd200);  grant_cycle(3, 1'b1, 8'd1);
        set_req(1, 3'd6, 8'h80, 8'd7);   grant_cycle(1, 1'b1, 8'd1);
        set_req(2, 3'd6, 8'hFF, 8'd8);   grant_cycle(2, 1'b1, 8'd0);
        set_req(0, 3'd5, 8'd1, 8'd7);    grant_cycle(0, 1'b1, 8'h80);
        set_req(3, 3'd4, 8'h5A, 8'h5A);  grant_cycle(3, 1'b1, 8'd0);

        for (int k = 0; k < 6; k++) begin
            rid = int'($urandom_range(3, 0));
            rop = 3'($urandom_range(7, 0));
            ra  = 8'($urandom_range(255, 0));
            rb  = 8'($urandom_range(12, 0));
            set_req(rid, rop, ra, rb);
            grant_cycle(rid, 1'b1, model(rop, ra, rb));
        end

        // Fairness: last grant 2, then 0 and 3 together -> 3 first
        set_req(2, 3'd2, 8'hF0, 8'h3C); grant_cycle(2, 1'b1, 8'h30);
        set_req(0, 3'd3, 8'h01, 8'h10);
        set_req(3, 3'd0, 8'd1, 8'd2);
        grant_cycle(3, 1'b1, 8'd3);
        grant_cycle(0, 1'b1, 8'h11);

        // Fresh reset, then all four continuously valid
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 3'(i), 8'(8'h13 + 8'(16 * i)), 8'(8'h0F + i));
        end
        for (int k = 0; k < 5; k++) begin
            grant_cycle(k % 4, 1'b0, model(3'(k % 4), 8'(8'h13 + 8'(16 * (k % 4))), 8'(8'h0F + (k % 4))));
        end
        req_valid = '0;

        // Backpressure with another requester waiting
        resp_ready = 1'b0;
        set_req(0, 3'd4, 8'hA5, 8'h0F);
        hold_res = 8'hAA;
        @(negedge clk);
        chk("bp_grant", 32'(req_ready), 32'd1);
        q.push_back('{id: 2'd0, res: hold_res, zero: 1'b0});
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        set_req(2, 3'd0, 8'd7, 8'd8);
        @(posedge clk); #1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_result", 32'(resp_result), 32'(hold_res));
            chk("bp_id", 32'(resp_id), 32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(negedge clk);
`ifdef ALU_ARB_STATS_EN
        chk("stat_stall", 32'(stat_stall), 32'd5);
        chk("stat_ops_before", 32'(stat_ops), 32'd5);
`endif
        @(posedge clk); #1;
        grant_cycle(2, 1'b1, 8'd15);
`ifdef ALU_ARB_STATS_EN
        chk("stat_ops_after", 32'(stat_ops), 32'd7);
`endif

        // Reset during EXEC discards the op
        set_req(3, 3'd0, 8'd1, 8'd1);
        @(negedge clk);
        chk("rx_grant", 32'(req_ready), 32'd8);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rx_resp_valid_async", 32'(resp_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rx_no_resp", 32'(resp_valid), 32'd0);
        end
        @(posedge clk); #1;
        set_req(3, 3'd1, 8'd9, 8'd4);
        set_req(0, 3'd0, 8'd250, 8'd10);
        grant_cycle(0, 1'b1, 8'd4);
        grant_cycle(3, 1'b1, 8'd5);

        @(negedge clk);
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
